// File: rtl/dmem_responder.sv
// dmem_responder
//   Multi-cycle, byte-addressable, little-endian data memory for the MEM stage.
//   One request is outstanding at a time. The storage is read and written only on
//   the edge that enters RESP. A response is held until the consumer accepts it.
//   busy tells the hazard unit to freeze the pipe while an access is in flight.
//   start is the asynchronous active-low reset. It also clears every storage word.
module dmem_responder #(
    parameter int DEPTH   = 64,   // number of 32-bit words
    parameter int LATENCY = 2     // accept edge to resp_valid, 1..15 cycles
) (
    input  logic        clk,
    input  logic        start,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        alive;        // low during reset, high from the first edge after release
    logic        accept;
    logic        enter_resp;
    logic        resp_hs;

    // Request captured at acceptance
    logic        rq_write;
    logic [1:0]  rq_size;
    logic        rq_unsigned;
    logic [31:0] rq_addr;
    logic [31:0] rq_wdata;

    // Request seen by the storage on the access edge
    logic        a_write;
    logic [1:0]  a_size;
    logic        a_unsigned;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;

    logic [1:0]       lane;
    logic [IDX_W-1:0] idx;
    logic             a_err;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      ld_data;
    logic [3:0]       be;
    logic [31:0]      wr_rep;
    logic [31:0]      st_word;
    logic             commit;

    logic [31:0] mem [DEPTH];

    // State register
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    // Next state, handshake outputs and access strobes
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        enter_resp = 1'b0;
        resp_hs    = 1'b0;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = alive;
                if (req_valid && alive) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    resp_hs   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ready enable and latency counter
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            alive <= 1'b0;
            cnt   <= '0;
        end else begin
            alive <= 1'b1;
            if (accept) begin
                cnt <= 4'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Request capture on the acceptance edge
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            rq_write    <= 1'b0;
            rq_size     <= '0;
            rq_unsigned <= 1'b0;
            rq_addr     <= '0;
            rq_wdata    <= '0;
        end else if (accept) begin
            rq_write    <= req_write;
            rq_size     <= req_size;
            rq_unsigned <= req_unsigned;
            rq_addr     <= req_addr;
            rq_wdata    <= req_wdata;
        end
    end

    // Select the access source: with LATENCY==1 the access edge is also the accept edge
    always_comb begin
        a_write    = rq_write;
        a_size     = rq_size;
        a_unsigned = rq_unsigned;
        a_addr     = rq_addr;
        a_wdata    = rq_wdata;
        if (state == IDLE) begin
            a_write    = req_write;
            a_size     = req_size;
            a_unsigned = req_unsigned;
            a_addr     = req_addr;
            a_wdata    = req_wdata;
        end
    end

    // Error decode, lane extraction for loads, and lane merge for stores
    always_comb begin
        lane  = a_addr[1:0];
        idx   = a_addr[IDX_W+1:2];
        a_err = (a_size == 2'b11)
             || (a_size == SZ_HALF && a_addr[0])
             || (a_size == SZ_WORD && a_addr[1:0] != 2'b00)
             || (a_addr[31:2] >= 30'(DEPTH));

        rd_word = mem[idx];
        rd_byte = rd_word[{lane, 3'b000} +: 8];
        rd_half = rd_word[{lane[1], 4'b0000} +: 16];

        ld_data = '0;
        be      = 4'b0000;
        wr_rep  = a_wdata;
        case (a_size)
            SZ_BYTE: begin
                ld_data = a_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                be      = 4'b0001 << lane;
                wr_rep  = {4{a_wdata[7:0]}};
            end
            SZ_HALF: begin
                ld_data = a_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
                be      = lane[1] ? 4'b1100 : 4'b0011;
                wr_rep  = {2{a_wdata[15:0]}};
            end
            SZ_WORD: begin
                ld_data = rd_word;
                be      = 4'b1111;
            end
            default: ;
        endcase
        if (a_write || a_err) begin
            ld_data = '0;
        end

        st_word = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                st_word[8*b +: 8] = wr_rep[8*b +: 8];
            end
        end

        commit = enter_resp && a_write && !a_err;
    end

    // Storage array: cleared by reset, written only on a committing access edge
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            // NOTE: the array is built from resettable flops because reset must clear every word.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit) begin
            mem[idx] <= st_word;
        end
    end

    // Response payload: loaded on entering RESP, cleared on the response handshake
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (enter_resp) begin
            resp_rdata <= ld_data;
            resp_err   <= a_err;
        end else if (resp_hs) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Table-driven directed vectors, hand-written reset/backpressure sequences, and a
//   randomized phase checked against a byte-array reference model of the memory.
//   A second instance built with LATENCY=1 checks the short-latency path.
module tb_dmem_responder;

    localparam int DEPTH   = 64;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        start;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    // Signals of the LATENCY=1 instance
    logic        l1_req_valid;
    logic        l1_req_ready;
    logic        l1_req_write;
    logic [1:0]  l1_req_size;
    logic        l1_req_unsigned;
    logic [31:0] l1_req_addr;
    logic [31:0] l1_req_wdata;
    logic        l1_resp_valid;
    logic        l1_resp_ready;
    logic [31:0] l1_resp_rdata;
    logic        l1_resp_err;
    logic        l1_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk          (clk),
        .start        (start),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .busy         (busy)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
        .clk          (clk),
        .start        (start),
        .req_valid    (l1_req_valid),
        .req_ready    (l1_req_ready),
        .req_write    (l1_req_write),
        .req_size     (l1_req_size),
        .req_unsigned (l1_req_unsigned),
        .req_addr     (l1_req_addr),
        .req_wdata    (l1_req_wdata),
        .resp_valid   (l1_resp_valid),
        .resp_ready   (l1_resp_ready),
        .resp_rdata   (l1_resp_rdata),
        .resp_err     (l1_resp_err),
        .busy         (l1_busy)
    );

    // Reference model: flat little-endian byte array
    logic [7:0] bmem [4*DEPTH];

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 4*DEPTH; i++) bmem[i] = 8'h00;
    endfunction

    function automatic void model_access(input logic w, input logic [1:0] sz, input logic uns,
                                         input logic [31:0] addr, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic err);
        int unsigned nbytes;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err = (sz == 2'd3) || (addr % nbytes != 0) || (addr >= 32'(4*DEPTH));
        rd  = 32'h0;
        if (err) return;
        if (w) begin
            for (int unsigned i = 0; i < nbytes; i++) bmem[addr + i] = 8'(wd >> (8*i));
        end else begin
            for (int unsigned i = 0; i < nbytes; i++) rd = rd | (32'(bmem[addr + i]) << (8*i));
            if (!uns && nbytes < 4 && rd >= (32'd1 << (8*nbytes - 1)))
                rd = rd - (32'd1 << (8*nbytes));
        end
    endfunction

    function automatic void add(input logic w, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd, input int hold,
                                input logic [31:0] exp_rd, input logic exp_err);
        vec_t v;
        v.w = w; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wd;
        v.hold = hold; v.exp_rd = exp_rd; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    // Waits for req_ready, runs one transaction on the LATENCY=2 instance and checks the
    // handshake timing along the way. Called and returning at posedge+1.
    task automatic run_op(input string name, input logic w, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input int hold,
                          input logic [31:0] exp_rd, input logic exp_err);
        int n;
        logic [31:0] rd;
        logic        er;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) begin
            check({name, "_ready_timeout"}, req_ready, 1);
            return;
        end
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        // Scramble the request bus: the access must use the captured request
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        for (int e = 0; e < LATENCY - 1; e++) begin
            check({name, "_wait_valid"}, resp_valid, 0);
            check({name, "_wait_busy"}, busy, 1);
            check({name, "_wait_ready"}, req_ready, 0);
            @(posedge clk); #1;
        end
        check({name, "_valid"}, resp_valid, 1);
        check({name, "_resp_ready"}, req_ready, 0);
        check({name, "_rdata"}, resp_rdata, exp_rd);
        check({name, "_err"}, resp_err, exp_err);
        rd = resp_rdata;
        er = resp_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({name, "_hold_valid"}, resp_valid, 1);
            check({name, "_hold_rdata"}, resp_rdata, rd);
            check({name, "_hold_err"}, resp_err, er);
            check({name, "_hold_ready"}, req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({name, "_post_valid"}, resp_valid, 0);
        check({name, "_post_rdata"}, resp_rdata, 0);
        check({name, "_post_err"}, resp_err, 0);
        check({name, "_post_busy"}, busy, 0);
        check({name, "_post_ready"}, req_ready, 1);
    endtask

    task automatic model_and_run(input string name, input logic w, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                                 input int hold);
        logic [31:0] mrd;
        logic        merr;
        model_access(w, sz, uns, addr, wd, mrd, merr);
        run_op(name, w, sz, uns, addr, wd, hold, mrd, merr);
    endtask

    initial begin
        logic [31:0] mrd;
        logic        merr;
        int          n;

        start = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        l1_req_valid = 1'b0; l1_req_write = 1'b0; l1_req_size = 2'd0; l1_req_unsigned = 1'b0;
        l1_req_addr = '0; l1_req_wdata = '0; l1_resp_ready = 1'b0;
        model_clear();

        // Reset behaviour: outputs low during reset, req_ready rises on the first edge after release
        #12;
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_err", resp_err, 0);
        check("rst_busy", busy, 0);
        #10 start = 1'b1;
        #1;
        check("rel_ready_before_edge", req_ready, 0);
        @(posedge clk); #1;
        check("rel_ready_after_edge", req_ready, 1);
        check("rel_busy", busy, 0);

        // Every word reads zero after reset
        for (int i = 0; i < DEPTH; i++)
            run_op($sformatf("zero_w%0d", i), 1'b0, 2'd2, 1'b0, 32'(4*i), 32'h0, 0, 32'h0, 1'b0);

        // Directed vectors: {write, size, unsigned, addr, wdata, hold, exp_rdata, exp_err}
        add(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0,        0);
        add(0, 2'd2, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF, 0);
        add(1, 2'd0, 0, 32'h11, 32'h12345680, 0, 32'h0,        0);
        add(0, 2'd2, 0, 32'h10, 32'h0,        0, 32'hDEAD80EF, 0);
        add(0, 2'd0, 0, 32'h11, 32'h0,        0, 32'hFFFFFF80, 0);
        add(0, 2'd0, 1, 32'h11, 32'h0,        0, 32'h00000080, 0);
        add(0, 2'd1, 0, 32'h12, 32'h0,        0, 32'hFFFFDEAD, 0);
        add(0, 2'd1, 1, 32'h12, 32'h0,        0, 32'h0000DEAD, 0);
        add(0, 2'd1, 0, 32'h10, 32'h0,        0, 32'hFFFF80EF, 0);
        add(0, 2'd1, 0, 32'h13, 32'h0,        0, 32'h0,        1);
        add(1, 2'd2, 0, 32'h12, 32'h11111111, 0, 32'h0,        1);
        add(0, 2'd3, 0, 32'h10, 32'h0,        0, 32'h0,        1);
        add(1, 2'd3, 0, 32'h10, 32'h0,        0, 32'h0,        1);
        add(0, 2'd2, 0, 32'h100, 32'h0,       0, 32'h0,        1);
        add(1, 2'd1, 0, 32'h80000010, 32'h0,  0, 32'h0,        1);
        add(0, 2'd2, 0, 32'h10, 32'h0,        5, 32'hDEAD80EF, 0);
        add(1, 2'd1, 0, 32'h02, 32'hFFFF1234, 0, 32'h0,        0);
        add(0, 2'd2, 0, 32'h00, 32'h0,        0, 32'h12340000, 0);
        add(1, 2'd0, 0, 32'hFF, 32'h000000AA, 2, 32'h0,        0);
        add(0, 2'd2, 0, 32'hFC, 32'h0,        0, 32'hAA000000, 0);
        add(0, 2'd0, 0, 32'hFF, 32'h0,        0, 32'hFFFFFFAA, 0);
        add(0, 2'd2, 0, 32'hFF, 32'h0,        0, 32'h0,        1);

        for (int i = 0; i < vecs.size(); i++) begin
            model_access(vecs[i].w, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wdata, mrd, merr);
            run_op($sformatf("vec%0d", i), vecs[i].w, vecs[i].sz, vecs[i].uns, vecs[i].addr,
                   vecs[i].wdata, vecs[i].hold, vecs[i].exp_rd, vecs[i].exp_err);
        end

        // Randomized phase against the byte-array model
        for (int i = 0; i < 80; i++) begin
            logic        w;
            logic [1:0]  sz;
            logic [31:0] addr;
            w  = 1'($urandom);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0)
                addr = 32'(4*DEPTH) + $urandom_range(0, 4095);
            else if ($urandom_range(0, 1) == 0)
                addr = 32'($urandom_range(0, 31));
            else
                addr = 32'($urandom_range(0, 4*DEPTH - 1));
            model_and_run($sformatf("rnd%0d", i), w, sz, 1'($urandom), addr, $urandom,
                          $urandom_range(0, 2));
        end

        // Reset during WAIT aborts a pending store; the array still clears
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("abort_ready", req_ready, 1);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h00000055;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_in_wait_busy", busy, 1);
        start = 1'b0;
        #1;
        check("abort_req_ready", req_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_resp_valid", resp_valid, 0);
        check("abort_rdata", resp_rdata, 0);
        check("abort_err", resp_err, 0);
        @(negedge clk);
        start = 1'b1;
        model_clear();
        @(posedge clk); #1;
        check("abort_ready_after_release", req_ready, 1);
        model_and_run("abort_lw20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);
        run_op("abort_lw20_const", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, 32'h0, 1'b0);
        run_op("abort_lw10_cleared", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, 32'h0, 1'b0);

        // LATENCY=1 instance: resp_valid one cycle after accept
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (!l1_req_ready && n < 20) begin
                @(posedge clk); #1; n++;
            end
            check("l1_ready", l1_req_ready, 1);
            l1_req_valid = 1'b1; l1_req_write = (k == 0); l1_req_size = 2'd2;
            l1_req_unsigned = 1'b0; l1_req_addr = 32'h4; l1_req_wdata = 32'h12345678;
            check("l1_valid_before_accept", l1_resp_valid, 0);
            @(posedge clk); #1;
            l1_req_valid = 1'b0; l1_req_addr = $urandom; l1_req_write = 1'($urandom);
            check($sformatf("l1_valid_op%0d", k), l1_resp_valid, 1);
            check($sformatf("l1_busy_op%0d", k), l1_busy, 1);
            check($sformatf("l1_err_op%0d", k), l1_resp_err, 0);
            check($sformatf("l1_rdata_op%0d", k), l1_resp_rdata, (k == 0) ? 32'h0 : 32'h12345678);
            l1_resp_ready = 1'b1;
            @(posedge clk); #1;
            l1_resp_ready = 1'b0;
            check($sformatf("l1_post_valid_op%0d", k), l1_resp_valid, 0);
            check($sformatf("l1_post_ready_op%0d", k), l1_req_ready, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "time limit");
    end

endmodule
